// File: rtl/tap_loader_if.sv
// tap_loader_if: stream-in, RAM port-B and status bundle for the TAP loader
interface tap_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  ram_d_b;
  logic [15:0] ram_ad_b;
  logic        ram_cs_b;
  logic        ram_we_b;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [7:0]  file_type;
  logic        autorun;
  modport master (
    output start, in_data, in_valid, in_last,
    input  in_ready, ram_d_b, ram_ad_b, ram_cs_b, ram_we_b,
    input  busy, done, error, start_addr, end_addr, file_type, autorun
  );
  modport slave (
    input  start, in_data, in_valid, in_last,
    output in_ready, ram_d_b, ram_ad_b, ram_cs_b, ram_we_b,
    output busy, done, error, start_addr, end_addr, file_type, autorun
  );
endinterface

// File: rtl/tap_loader.sv
// tap_loader: parses a TAP byte stream (sync, header, name) and writes the data block into RAM port B
module tap_loader #(
  parameter int MIN_SYNC = 3,
  parameter int NAME_MAX = 16
) (
  input logic        clk_sys,
  input logic        reset,
  tap_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SYNC, HDR, NAME, DATA, DONE, ERR} state_t;
  localparam int SW = $clog2(MIN_SYNC + 2);
  localparam int NW = $clog2(NAME_MAX + 2);
  localparam logic [SW-1:0] SYNC_MAX = SW'(MIN_SYNC);
  localparam logic [NW-1:0] NAME_LIM = NW'(NAME_MAX + 1);
  state_t state_q, state_d;
  logic [SW-1:0] sync_q, sync_d;
  logic [3:0] hdr_q, hdr_d;
  logic [NW-1:0] name_q, name_d;
  logic [15:0] addr_q, addr_d, start_q, start_d, end_q, end_d, wa_q, wa_d;
  logic [7:0] ft_q, ft_d, wd_q, wd_d;
  logic ar_q, ar_d, we_q, we_d;
  logic xfer;
  // State and datapath registers; reset wins over start and any transfer
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hdr_q   <= '0;
      name_q  <= '0;
      addr_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      ft_q    <= '0;
      ar_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hdr_q   <= hdr_d;
      name_q  <= name_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      end_q   <= end_d;
      ft_q    <= ft_d;
      ar_q    <= ar_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
    end
  end
  assign xfer = bus.in_valid && bus.in_ready;
  // Next state, counters, header capture and the one-cycle RAM write
  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    hdr_d   = hdr_q;
    name_d  = name_q;
    addr_d  = addr_q;
    start_d = start_q;
    end_d   = end_q;
    ft_d    = ft_q;
    ar_d    = ar_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    if (bus.start) begin
      state_d = SYNC;
      sync_d  = '0;
      hdr_d   = '0;
      name_d  = '0;
    end else if (xfer) begin
      unique case (state_q)
        SYNC: begin
          sync_d  = bus.in_data == 8'h16 ? (sync_q == SYNC_MAX ? sync_q : sync_q + 1'b1) : '0;
          state_d = (bus.in_data == 8'h24 && sync_q >= SYNC_MAX) ? HDR : SYNC;
          hdr_d   = '0;
        end
        HDR: begin
          ft_d    = hdr_q == 4'd2 ? bus.in_data : ft_q;
          ar_d    = hdr_q == 4'd3 ? |bus.in_data : ar_q;
          end_d   = hdr_q == 4'd4 ? {bus.in_data, end_q[7:0]} : hdr_q == 4'd5 ? {end_q[15:8], bus.in_data} : end_q;
          start_d = hdr_q == 4'd6 ? {bus.in_data, start_q[7:0]} : hdr_q == 4'd7 ? {start_q[15:8], bus.in_data} : start_q;
          hdr_d   = hdr_q + 4'd1;
          state_d = hdr_q == 4'd8 ? NAME : HDR;
          name_d  = '0;
        end
        NAME: begin
          name_d  = bus.in_data == 8'h00 ? name_q : name_q + 1'b1;
          addr_d  = start_q;
          state_d = bus.in_data == 8'h00 ? (end_q < start_q ? ERR : DATA) : (name_q + 1'b1 == NAME_LIM ? ERR : NAME);
        end
        DATA: begin
          we_d    = 1'b1;
          wa_d    = addr_q;
          wd_d    = bus.in_data;
          addr_d  = addr_q + 16'd1;
          state_d = addr_q == end_q ? DONE : DATA;
        end
        default: ;
      endcase
      state_d = (bus.in_last && state_d != DONE) ? ERR : state_d;
    end
  end
  // Handshake and status decoded from state; RAM and header outputs straight from flops
  always_comb begin
    bus.in_ready = state_q inside {SYNC, HDR, NAME, DATA};
    bus.busy     = state_q inside {SYNC, HDR, NAME, DATA};
    bus.done     = state_q == DONE;
    bus.error    = state_q == ERR;
  end
  assign bus.ram_d_b    = wd_q;
  assign bus.ram_ad_b   = wa_q;
  assign bus.ram_cs_b   = we_q;
  assign bus.ram_we_b   = we_q;
  assign bus.start_addr = start_q;
  assign bus.end_addr   = end_q;
  assign bus.file_type  = ft_q;
  assign bus.autorun    = ar_q;
endmodule
